// File: rtl/gmii_udp_recv.sv
// rtl/gmii_udp_recv.sv - GMII receive-side Ethernet II / IPv4 / UDP payload extractor
`timescale 1ns/1ps
module gmii_udp_recv #(
  parameter logic [47:0] BOARD_MAC    = 48'h11_45_14_19_19_81,
  parameter logic [31:0] BOARD_IP     = {8'd192, 8'd168, 8'd3, 8'd2},
  parameter logic [15:0] BOARD_PORT   = 16'h8000,
  parameter bit          CHECK_IP_SUM = 1'b1
) (
  input  logic        GMII_RXCLK,
  input  logic        rst_n,
  input  logic [7:0]  GMII_RXD,
  input  logic        GMII_RXDV,
  input  logic        GMII_RXER,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  input  logic        wr_full,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [15:0] pkt_len
);

  typedef enum logic [2:0] {
    ST_WAIT_END,
    ST_IDLE,
    ST_PREAMBLE,
    ST_ETH_HDR,
    ST_IP_HDR,
    ST_UDP_HDR,
    ST_PAYLOAD
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_hdr_ok;
  logic        r_mac_hit;
  logic        r_bc_hit;
  logic [7:0]  r_csum_hi;
  logic [16:0] r_csum_acc;
  logic [15:0] r_ip_len;
  logic [15:0] r_udp_len;
  logic [15:0] r_pay_cnt;
  logic [15:0] r_pay_tgt;

  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic        w_byte_ok;
  logic [15:0] w_word;
  logic [16:0] w_acc_next;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic        w_sum_ok;
  logic        w_udp_len_ok;
  logic [15:0] w_pay_len;
  logic [15:0] w_pay_cnt_next;

  // One's-complement header sum: end-around carry per word, then fold twice at the end
  assign w_word         = {r_csum_hi, GMII_RXD};
  assign w_acc_next     = {1'b0, r_csum_acc[15:0]} + {16'd0, r_csum_acc[16]} + {1'b0, w_word};
  assign w_fold1        = {1'b0, w_acc_next[15:0]} + {16'd0, w_acc_next[16]};
  assign w_fold2        = w_fold1[15:0] + {15'd0, w_fold1[16]};
  assign w_sum_ok       = (CHECK_IP_SUM == 1'b0) || (w_fold2 == 16'hFFFF);
  assign w_udp_len_ok   = (r_udp_len >= 16'd8) && (r_ip_len >= 16'd20) &&
                          (r_udp_len <= r_ip_len - 16'd20);
  assign w_pay_len      = r_udp_len - 16'd8;
  assign w_pay_cnt_next = r_pay_cnt + 16'd1;

  // Per-byte header field checks for the byte currently on GMII_RXD
  always_comb begin
    w_mac_byte = 8'h00;
    w_ip_byte  = 8'h00;
    w_byte_ok  = 1'b1;
    case (r_cnt)
      5'd0:  w_mac_byte = BOARD_MAC[47:40];
      5'd1:  w_mac_byte = BOARD_MAC[39:32];
      5'd2:  w_mac_byte = BOARD_MAC[31:24];
      5'd3:  w_mac_byte = BOARD_MAC[23:16];
      5'd4:  w_mac_byte = BOARD_MAC[15:8];
      5'd5:  w_mac_byte = BOARD_MAC[7:0];
      5'd16: w_ip_byte  = BOARD_IP[31:24];
      5'd17: w_ip_byte  = BOARD_IP[23:16];
      5'd18: w_ip_byte  = BOARD_IP[15:8];
      5'd19: w_ip_byte  = BOARD_IP[7:0];
      default: ;
    endcase
    case (r_state)
      ST_ETH_HDR: begin
        if (r_cnt == 5'd12) w_byte_ok = (GMII_RXD == 8'h08);
        else if (r_cnt == 5'd13) w_byte_ok = (GMII_RXD == 8'h00);
      end
      ST_IP_HDR: begin
        if (r_cnt == 5'd0) w_byte_ok = (GMII_RXD == 8'h45);
        else if (r_cnt == 5'd9) w_byte_ok = (GMII_RXD == 8'h11);
        else if (r_cnt >= 5'd16) w_byte_ok = (GMII_RXD == w_ip_byte);
      end
      ST_UDP_HDR: begin
        if (r_cnt == 5'd2) w_byte_ok = (GMII_RXD == BOARD_PORT[15:8]);
        else if (r_cnt == 5'd3) w_byte_ok = (GMII_RXD == BOARD_PORT[7:0]);
      end
      default: ;
    endcase
  end

  // Frame parser FSM with registered FIFO write and packet status outputs
  always_ff @(posedge GMII_RXCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_END;
      r_cnt      <= 5'd0;
      r_hdr_ok   <= 1'b0;
      r_mac_hit  <= 1'b0;
      r_bc_hit   <= 1'b0;
      r_csum_hi  <= 8'h00;
      r_csum_acc <= 17'd0;
      r_ip_len   <= 16'd0;
      r_udp_len  <= 16'd0;
      r_pay_cnt  <= 16'd0;
      r_pay_tgt  <= 16'd0;
      wr_data    <= 8'h00;
      wr_en      <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_err    <= 1'b0;
      pkt_len    <= 16'd0;
    end else begin
      wr_en    <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      case (r_state)
        ST_WAIT_END: begin
          if (!GMII_RXDV) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (GMII_RXDV) r_state <= (GMII_RXD == 8'h55) ? ST_PREAMBLE : ST_WAIT_END;
        end
        ST_PREAMBLE: begin
          if (!GMII_RXDV) begin
            r_state <= ST_IDLE;
          end else if (GMII_RXD == 8'hD5) begin
            r_state    <= ST_ETH_HDR;
            r_cnt      <= 5'd0;
            r_hdr_ok   <= 1'b1;
            r_mac_hit  <= 1'b1;
            r_bc_hit   <= 1'b1;
            r_csum_acc <= 17'd0;
          end else if (GMII_RXD != 8'h55) begin
            r_state <= ST_WAIT_END;
          end
        end
        ST_ETH_HDR: begin
          if (!GMII_RXDV) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_byte_ok) r_hdr_ok <= 1'b0;
            if (r_cnt < 5'd6) begin
              if (GMII_RXD != w_mac_byte) r_mac_hit <= 1'b0;
              if (GMII_RXD != 8'hFF) r_bc_hit <= 1'b0;
            end
            if (r_cnt == 5'd13) begin
              r_cnt    <= 5'd0;
              r_hdr_ok <= 1'b1;
              r_state  <= (r_hdr_ok && w_byte_ok && (r_mac_hit || r_bc_hit)) ? ST_IP_HDR : ST_WAIT_END;
            end
          end
        end
        ST_IP_HDR: begin
          if (!GMII_RXDV) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_byte_ok) r_hdr_ok <= 1'b0;
            if (!r_cnt[0]) r_csum_hi <= GMII_RXD;
            else r_csum_acc <= w_acc_next;
            if (r_cnt == 5'd2) r_ip_len[15:8] <= GMII_RXD;
            if (r_cnt == 5'd3) r_ip_len[7:0] <= GMII_RXD;
            if (r_cnt == 5'd19) begin
              r_cnt    <= 5'd0;
              r_hdr_ok <= 1'b1;
              r_state  <= (r_hdr_ok && w_byte_ok && w_sum_ok) ? ST_UDP_HDR : ST_WAIT_END;
            end
          end
        end
        ST_UDP_HDR: begin
          if (!GMII_RXDV) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_byte_ok) r_hdr_ok <= 1'b0;
            if (r_cnt == 5'd4) r_udp_len[15:8] <= GMII_RXD;
            if (r_cnt == 5'd5) r_udp_len[7:0] <= GMII_RXD;
            if (r_cnt == 5'd7) begin
              r_cnt   <= 5'd0;
              r_state <= ST_WAIT_END;
              if (r_hdr_ok && w_byte_ok && w_udp_len_ok) begin
                if (w_pay_len == 16'd0) begin
                  pkt_done <= 1'b1;
                  pkt_len  <= 16'd0;
                end else begin
                  r_state   <= ST_PAYLOAD;
                  r_pay_cnt <= 16'd0;
                  r_pay_tgt <= w_pay_len;
                end
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (!GMII_RXDV) begin
            pkt_err <= 1'b1;
            r_state <= ST_IDLE;
          end else if (GMII_RXER || wr_full) begin
            pkt_err <= 1'b1;
            r_state <= ST_WAIT_END;
          end else begin
            wr_data   <= GMII_RXD;
            wr_en     <= 1'b1;
            r_pay_cnt <= w_pay_cnt_next;
            if (w_pay_cnt_next == r_pay_tgt) begin
              pkt_done <= 1'b1;
              pkt_len  <= r_pay_tgt;
              r_state  <= ST_WAIT_END;
            end
          end
        end
        default: r_state <= ST_WAIT_END;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_udp_recv.sv
// tb/tb_gmii_udp_recv.sv - randomized self-checking bench for gmii_udp_recv
`timescale 1ns/1ps
module tb_gmii_udp_recv;

  localparam logic [47:0] MAC  = 48'h11_45_14_19_19_81;
  localparam logic [31:0] IP   = {8'd192, 8'd168, 8'd3, 8'd2};
  localparam logic [15:0] PORT = 16'h8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rxd;
  logic        rxdv, rxer, full;
  logic [7:0]  wr_data, nc_wr_data;
  logic        wr_en, pkt_done, pkt_err;
  logic        nc_wr_en, nc_pkt_done, nc_pkt_err;
  logic [15:0] pkt_len, nc_pkt_len;

  always #4 clk = ~clk;

  gmii_udp_recv u_dut (
    .GMII_RXCLK(clk), .rst_n(rst_n), .GMII_RXD(rxd), .GMII_RXDV(rxdv), .GMII_RXER(rxer),
    .wr_data(wr_data), .wr_en(wr_en), .wr_full(full),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_len(pkt_len)
  );

  gmii_udp_recv #(.CHECK_IP_SUM(1'b0)) u_dut_nc (
    .GMII_RXCLK(clk), .rst_n(rst_n), .GMII_RXD(rxd), .GMII_RXDV(rxdv), .GMII_RXER(rxer),
    .wr_data(nc_wr_data), .wr_en(nc_wr_en), .wr_full(full),
    .pkt_done(nc_pkt_done), .pkt_err(nc_pkt_err), .pkt_len(nc_pkt_len)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // observed
  logic [7:0] obs_q[$];
  int obs_done, obs_err, obs_done_wr, obs_bad, obs_nc_wr, obs_nc_done, obs_nc_err;
  // expected
  logic [7:0] exp_q[$];
  int exp_done, exp_err, exp_done_wr, exp_len, exp_nc_wr, exp_nc_done, exp_nc_err;

  logic [7:0] frm[$];
  int         frm_p;

  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) obs_q.push_back(wr_data);
      if (pkt_done) begin
        obs_done++;
        if (wr_en) obs_done_wr++;
      end
      if (pkt_err) begin
        obs_err++;
        if (wr_en || pkt_done) obs_bad++;
      end
      if (nc_wr_en) obs_nc_wr++;
      if (nc_pkt_done) obs_nc_done++;
      if (nc_pkt_err) obs_nc_err++;
    end
  end

  task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] ver,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                       input logic [15:0] ulen, input logic [15:0] ilen, input int npay,
                       input bit bad_sum, input int ntail, input int npre);
    logic [7:0]  ip[20];
    int          sum;
    logic [15:0] cs;
    frm.delete();
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    ip[0] = ver; ip[1] = 8'h00; ip[2] = ilen[15:8]; ip[3] = ilen[7:0];
    ip[4] = 8'($urandom); ip[5] = 8'($urandom); ip[6] = 8'h40; ip[7] = 8'h00;
    ip[8] = 8'h40; ip[9] = proto; ip[10] = 8'h00; ip[11] = 8'h00;
    for (int i = 12; i < 16; i++) ip[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ip[16+i] = dip[31-8*i -: 8];
    sum = 0;
    for (int k = 0; k < 10; k++) sum += {ip[2*k], ip[2*k+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    if (bad_sum) cs = cs ^ (16'h0001 << $urandom_range(0, 15));
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(ip[i]);
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    frm_p = frm.size();
    repeat (npay) frm.push_back(8'($urandom));
    repeat (ntail) frm.push_back(8'($urandom));
  endtask

  // Reference: parse the bytes that will actually be sent and decide what each receiver should do
  task automatic model(input int nsent, input int er_idx, input int full_idx, input int rst_idx, input bit synced);
    int s, e, u, p, n, sum, wr, res;
    logic [47:0] dst;
    logic [31:0] dip;
    logic [15:0] et, il, ul, dp;
    bit hdr_ok, sum_ok;
    if (rst_idx >= 0) exp_len = 0;
    if (!synced) return;
    s = 0;
    while (s < nsent && frm[s] == 8'h55) s++;
    if (s == 0 || s >= nsent || frm[s] != 8'hD5) return;
    s++;
    if (nsent < s + 42) return;
    if (rst_idx >= 0 && rst_idx < s + 42) return;
    e = s + 14; u = e + 20; p = u + 8;
    dst = '0; dip = '0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], frm[s+i]};
    for (int i = 0; i < 4; i++) dip = {dip[23:0], frm[e+16+i]};
    et = {frm[s+12], frm[s+13]};
    il = {frm[e+2], frm[e+3]};
    dp = {frm[u+2], frm[u+3]};
    ul = {frm[u+4], frm[u+5]};
    hdr_ok = (dst == MAC || dst == 48'hFFFF_FFFF_FFFF) && et == 16'h0800 && frm[e] == 8'h45 &&
             frm[e+9] == 8'h11 && dip == IP && dp == PORT && int'(ul) >= 8 && int'(ul) + 20 <= int'(il);
    sum = 0;
    for (int k = 0; k < 10; k++) sum += {frm[e+2*k], frm[e+2*k+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum_ok = (sum == 32'hFFFF);
    if (!hdr_ok) return;
    n = int'(ul) - 8;
    for (int inst = 0; inst < 2; inst++) begin
      if (inst == 0 && !sum_ok) continue;
      wr = 0; res = 0;
      for (int i = 0; i < n; i++) begin
        if (rst_idx >= 0 && p + i >= rst_idx) begin res = 2; break; end
        if (p + i >= nsent || p + i == er_idx || p + i == full_idx) begin res = 1; break; end
        wr++;
        if (inst == 0) exp_q.push_back(frm[p+i]);
      end
      if (inst == 0) begin
        if (res == 0) begin
          exp_done++;
          if (n > 0) exp_done_wr++;
          exp_len = n;
        end else if (res == 1) exp_err++;
      end else begin
        exp_nc_wr += wr;
        if (res == 0) exp_nc_done++;
        else if (res == 1) exp_nc_err++;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after `gap` idle cycles have been sampled
  task automatic send(input int nsent, input int er_idx, input int full_idx, input int rst_idx,
                      input int rel_idx, input int gap);
    for (int i = 0; i < nsent; i++) begin
      if (i == rst_idx) begin
        @(negedge clk); #1 rst_n = 1'b0; #1;
        check("async_reset_outputs", int'({wr_en, pkt_done, pkt_err, wr_data, pkt_len}), 0);
      end
      if (i == rel_idx) begin
        @(negedge clk); #1 rst_n = 1'b1;
      end
      rxdv = 1'b1; rxd = frm[i]; rxer = (i == er_idx); full = (i == full_idx);
      @(posedge clk); #1;
    end
    rxdv = 1'b0; rxd = 8'h00; rxer = 1'b0; full = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic flush(input string tag);
    int m;
    @(negedge clk); #1;
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_wr_data"}, obs_q[i], exp_q[i]);
    check({tag, "_done"}, obs_done, exp_done);
    check({tag, "_err"}, obs_err, exp_err);
    check({tag, "_done_with_last_wr"}, obs_done_wr, exp_done_wr);
    check({tag, "_err_overlap"}, obs_bad, 0);
    check({tag, "_pkt_len"}, pkt_len, exp_len);
    check({tag, "_nc_nwr"}, obs_nc_wr, exp_nc_wr);
    check({tag, "_nc_done"}, obs_nc_done, exp_nc_done);
    check({tag, "_nc_err"}, obs_nc_err, exp_nc_err);
    obs_q.delete(); exp_q.delete();
    obs_done = 0; obs_err = 0; obs_done_wr = 0; obs_bad = 0;
    obs_nc_wr = 0; obs_nc_done = 0; obs_nc_err = 0;
    exp_done = 0; exp_err = 0; exp_done_wr = 0;
    exp_nc_wr = 0; exp_nc_done = 0; exp_nc_err = 0;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input int nsent, input int er_idx, input int full_idx);
    model(nsent, er_idx, full_idx, -1, 1'b1);
    send(nsent, er_idx, full_idx, -1, -1, 3);
    flush(tag);
  endtask

  initial begin
    logic [47:0] dmac;
    logic [15:0] etype, dport, ulen, ilen;
    logic [7:0]  ver, proto;
    logic [31:0] dip;
    int n, kind, nsent, er, fl, gap;
    bit bad;

    exp_len = 0;
    rst_n = 1'b0; rxdv = 1'b1; rxd = 8'h55; rxer = 1'b0; full = 1'b0;
    obs_done = 0; obs_err = 0; obs_done_wr = 0; obs_bad = 0;
    obs_nc_wr = 0; obs_nc_done = 0; obs_nc_err = 0;
    exp_done = 0; exp_err = 0; exp_done_wr = 0;
    exp_nc_wr = 0; exp_nc_done = 0; exp_nc_err = 0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", int'({wr_en, pkt_done, pkt_err, wr_data, pkt_len}), 0);

    // Reset released while a valid frame is streaming: nothing may be accepted
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    model(frm.size(), -1, -1, -1, 1'b0);
    send(frm.size(), -1, -1, -1, 2, 3);
    flush("reset_midstream");

    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    frm[frm_p] = 8'hDE; frm[frm_p+1] = 8'hAD; frm[frm_p+2] = 8'hBE; frm[frm_p+3] = 8'hEF;
    run("deadbeef", frm.size(), -1, -1);
    check("deadbeef_len_const", pkt_len, 4);

    build(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    run("broadcast", frm.size(), -1, -1);
    build(48'h00_11_22_33_44_55, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    run("wrong_mac", frm.size(), -1, -1);
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, 16'h8001, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    run("wrong_port", frm.size(), -1, -1);
    build(MAC, 16'h0800, 8'h45, 8'h06, IP, PORT, 16'd12, 16'd32, 4, 1'b0, 4, 7);
    run("tcp_proto", frm.size(), -1, -1);
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd12, 16'd32, 4, 1'b1, 4, 7);
    run("bad_ip_sum", frm.size(), -1, -1);

    // FIFO full at payload byte 100, then a valid frame after one idle cycle
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd969, 16'd989, 961, 1'b0, 4, 7);
    model(frm.size(), -1, frm_p + 99, -1, 1'b1);
    send(frm.size(), -1, frm_p + 99, -1, -1, 1);
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd20, 16'd40, 12, 1'b0, 0, 7);
    model(frm.size(), -1, -1, -1, 1'b1);
    send(frm.size(), -1, -1, -1, -1, 1);
    flush("full_then_back2back");

    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd28, 16'd48, 20, 1'b0, 0, 7);
    run("rxdv_drop", frm_p + 10, -1, -1);
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd28, 16'd48, 20, 1'b0, 4, 7);
    run("rxer_byte5", frm.size(), frm_p + 4, -1);
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd8, 16'd28, 0, 1'b0, 18, 7);
    run("zero_payload", frm.size(), -1, -1);

    // Asynchronous reset in the middle of a payload
    build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd28, 16'd48, 20, 1'b0, 4, 7);
    model(frm.size(), -1, -1, frm_p + 10, 1'b1);
    send(frm.size(), -1, -1, frm_p + 10, frm_p + 12, 3);
    flush("async_reset_payload");

    for (int t = 0; t < 40; t++) begin
      dmac = MAC; etype = 16'h0800; ver = 8'h45; proto = 8'h11; dip = IP; dport = PORT;
      n = $urandom_range(0, 40);
      ulen = 16'(n + 8); ilen = 16'(n + 28); bad = 1'b0; er = -1; fl = -1;
      kind = $urandom_range(0, 15);
      case (kind)
        1:  dmac = 48'hFFFF_FFFF_FFFF;
        2:  dmac = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
        3:  dport = dport ^ (16'h0001 << $urandom_range(0, 15));
        4:  proto = 8'h06;
        5:  bad = 1'b1;
        9:  ilen = ulen + 16'd20 - 16'($urandom_range(1, 8));
        10: ilen = ilen + 16'($urandom_range(1, 10));
        11: begin ulen = 16'($urandom_range(0, 7)); ilen = 16'd28; end
        12: etype = 16'h86DD;
        13: ver = 8'h46;
        14: dip = dip ^ 32'h0000_0001;
        default: ;
      endcase
      build(dmac, etype, ver, proto, dip, dport, ulen, ilen, n, bad, $urandom_range(0, 6), $urandom_range(1, 7));
      nsent = frm.size();
      if (kind == 6) nsent = frm_p + $urandom_range(0, n);
      if (kind == 15) nsent = $urandom_range(1, frm_p - 1);
      if (kind == 7 && n > 0) er = frm_p + $urandom_range(0, n - 1);
      if (kind == 8 && n > 0) fl = frm_p + $urandom_range(0, n - 1);
      gap = $urandom_range(1, 3);
      model(nsent, er, fl, -1, 1'b1);
      send(nsent, er, fl, -1, -1, gap);
      flush($sformatf("rand%0d_k%0d", t, kind));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
